// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul_engine coprocessor.
package matmul_pkg;

   typedef enum logic [1:0] {StIdle, StCompute, StDone} state_t;

   localparam int unsigned DefN        = 4;
   localparam int unsigned DefDataW    = 8;
   localparam int unsigned DefAccW     = 20;
   localparam int unsigned DefSaturate = 0;

   // Bounds are bit patterns in the low acc_w bits (lo is the two's complement minimum).
   typedef struct packed {
      logic [63:0] hi;
      logic [63:0] lo;
   } sat_bounds_t;

   function automatic sat_bounds_t sat_bounds(input int unsigned acc_w, input logic is_signed);
      sat_bounds_t bnd;
      if (is_signed) begin
         bnd.hi = (64'd1 << (acc_w - 1)) - 64'd1;
         bnd.lo = 64'd1 << (acc_w - 1);
      end else begin
         bnd.hi = (64'd1 << acc_w) - 64'd1;
         bnd.lo = '0;
      end
      return bnd;
   endfunction

endpackage

// File: rtl/matmul_engine_mac.sv
// Combinational multiply-accumulate step with overflow detection and optional clamping.
module mac_unit
   import matmul_pkg::*;
#(
   parameter int unsigned DATA_W   = DefDataW,
   parameter int unsigned ACC_W    = DefAccW,
   parameter int unsigned SATURATE = DefSaturate
) (
   input  logic [ACC_W-1:0]  base,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              signed_mode,
   output logic [ACC_W-1:0]  result,
   output logic              ovf
);

   localparam int unsigned EW = ACC_W + 1;
   localparam sat_bounds_t UBnd = sat_bounds(ACC_W, 1'b0);
   localparam sat_bounds_t SBnd = sat_bounds(ACC_W, 1'b1);

   logic [EW-1:0] a_x, b_x, base_x, prod_x, sum_x;

   always_comb begin
      a_x    = {{(EW - DATA_W){signed_mode & a[DATA_W-1]}}, a};
      b_x    = {{(EW - DATA_W){signed_mode & b[DATA_W-1]}}, b};
      base_x = {signed_mode & base[ACC_W-1], base};
      // The true 2*DATA_W product always fits in EW bits, so a modulo-EW multiply is exact.
      prod_x = a_x * b_x;
      sum_x  = base_x + prod_x;
      ovf    = signed_mode ? (sum_x[EW-1] ^ sum_x[EW-2]) : sum_x[EW-1];
      result = sum_x[ACC_W-1:0];
      if (ovf && (SATURATE != 0)) begin
         if (!signed_mode) begin
            result = UBnd.hi[ACC_W-1:0];
         end else if (sum_x[EW-1]) begin
            result = SBnd.lo[ACC_W-1:0];
         end else begin
            result = SBnd.hi[ACC_W-1:0];
         end
      end
   end

endmodule

// File: rtl/matmul_engine.sv
// N x N matrix-multiply coprocessor: C = A*B or C += A*B, one MAC per cycle.
module matmul_engine
   import matmul_pkg::*;
#(
   parameter int unsigned N        = DefN,
   parameter int unsigned DATA_W   = DefDataW,
   parameter int unsigned ACC_W    = DefAccW,
   parameter int unsigned SATURATE = DefSaturate,
   localparam int unsigned AW      = $clog2(N * N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_wr_en,
   input  logic [AW-1:0]     a_wr_addr,
   input  logic [DATA_W-1:0] a_wr_data,
   input  logic              b_wr_en,
   input  logic [AW-1:0]     b_wr_addr,
   input  logic [DATA_W-1:0] b_wr_data,
   input  logic              start,
   input  logic              accumulate,
   input  logic              signed_mode,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   input  logic [AW-1:0]     c_rd_addr,
   output logic [ACC_W-1:0]  c_rd_data
);

   localparam int unsigned IW = $clog2(N);
   localparam logic [IW-1:0] IdxMax = IW'(N - 1);

   logic [DATA_W-1:0] a_mem [N*N];
   logic [DATA_W-1:0] b_mem [N*N];
   logic [ACC_W-1:0]  c_mem [N*N];

   state_t            state;
   logic [IW-1:0]     i, j, k;
   logic [ACC_W-1:0]  acc;
   logic              acc_mode, sgn_mode;

   logic [AW-1:0]     a_idx, b_idx, c_idx;
   logic [ACC_W-1:0]  mac_base, mac_result;
   logic              mac_ovf;
   logic              row_end;

   always_comb begin
      a_idx    = AW'(32'(i) * N + 32'(k));
      b_idx    = AW'(32'(k) * N + 32'(j));
      c_idx    = AW'(32'(i) * N + 32'(j));
      row_end  = (k == IdxMax);
      mac_base = acc;
      if (k == '0) begin
         mac_base = acc_mode ? c_mem[c_idx] : '0;
      end
   end

   mac_unit #(
      .DATA_W   (DATA_W),
      .ACC_W    (ACC_W),
      .SATURATE (SATURATE)
   ) u_mac (
      .base        (mac_base),
      .a           (a_mem[a_idx]),
      .b           (b_mem[b_idx]),
      .signed_mode (sgn_mode),
      .result      (mac_result),
      .ovf         (mac_ovf)
   );

   // Operand buffers are frozen while a job is running.
   always_ff @(posedge clk) begin
      if (a_wr_en && (state != StCompute)) begin
         a_mem[a_wr_addr] <= a_wr_data;
      end
      if (b_wr_en && (state != StCompute)) begin
         b_mem[b_wr_addr] <= b_wr_data;
      end
      if (!rst && (state == StCompute) && row_end) begin
         c_mem[c_idx] <= mac_result;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         c_rd_data <= '0;
      end else begin
         c_rd_data <= c_mem[c_rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= StIdle;
         i        <= '0;
         j        <= '0;
         k        <= '0;
         acc      <= '0;
         acc_mode <= 1'b0;
         sgn_mode <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start) begin
                  acc_mode <= accumulate;
                  sgn_mode <= signed_mode;
                  overflow <= 1'b0;
                  i        <= '0;
                  j        <= '0;
                  k        <= '0;
                  busy     <= 1'b1;
                  state    <= StCompute;
               end
            end
            StCompute: begin
               acc <= mac_result;
               if (mac_ovf) begin
                  overflow <= 1'b1;
               end
               if (row_end) begin
                  k <= '0;
                  if (j == IdxMax) begin
                     j <= '0;
                     if (i == IdxMax) begin
                        i     <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                     end else begin
                        i <= i + IW'(1);
                     end
                  end else begin
                     j <= j + IW'(1);
                  end
               end else begin
                  k <= k + IW'(1);
               end
            end
            StDone: begin
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_engine.sv
// Self-checking bench for matmul_engine: scoreboard of expected C values from a reference model.
module tb_matmul_engine;

   localparam int N  = 4;
   localparam int NN = N * N;

   typedef struct {
      int          addr;
      logic [19:0] exp;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_wr_en = 1'b0, b_wr_en = 1'b0;
   logic [3:0]  a_wr_addr = '0, b_wr_addr = '0;
   logic [7:0]  a_wr_data = '0, b_wr_data = '0;
   logic        start = 1'b0, accumulate = 1'b0, signed_mode = 1'b0;
   logic [3:0]  c_rd_addr = '0;

   logic        busy, done, overflow;
   logic [19:0] c_rd_data;
   logic        busy_s16, done_s16, ovf_s16;
   logic [15:0] c_rd_data_s16;
   logic        busy_w16, done_w16, ovf_w16;
   logic [15:0] c_rd_data_w16;

   int errors = 0;
   int checks = 0;

   logic [7:0]  a_m [NN];
   logic [7:0]  b_m [NN];
   logic [19:0] mc  [NN];
   bit          exp_ovf;
   sb_t         sb_q [$];

   always #5 clk = ~clk;

   matmul_engine dut (
      .clk (clk), .rst (rst),
      .a_wr_en (a_wr_en), .a_wr_addr (a_wr_addr), .a_wr_data (a_wr_data),
      .b_wr_en (b_wr_en), .b_wr_addr (b_wr_addr), .b_wr_data (b_wr_data),
      .start (start), .accumulate (accumulate), .signed_mode (signed_mode),
      .busy (busy), .done (done), .overflow (overflow),
      .c_rd_addr (c_rd_addr), .c_rd_data (c_rd_data)
   );

   matmul_engine #(.ACC_W (16), .SATURATE (1)) dut_s16 (
      .clk (clk), .rst (rst),
      .a_wr_en (a_wr_en), .a_wr_addr (a_wr_addr), .a_wr_data (a_wr_data),
      .b_wr_en (b_wr_en), .b_wr_addr (b_wr_addr), .b_wr_data (b_wr_data),
      .start (start), .accumulate (accumulate), .signed_mode (signed_mode),
      .busy (busy_s16), .done (done_s16), .overflow (ovf_s16),
      .c_rd_addr (c_rd_addr), .c_rd_data (c_rd_data_s16)
   );

   matmul_engine #(.ACC_W (16), .SATURATE (0)) dut_w16 (
      .clk (clk), .rst (rst),
      .a_wr_en (a_wr_en), .a_wr_addr (a_wr_addr), .a_wr_data (a_wr_data),
      .b_wr_en (b_wr_en), .b_wr_addr (b_wr_addr), .b_wr_data (b_wr_data),
      .start (start), .accumulate (accumulate), .signed_mode (signed_mode),
      .busy (busy_w16), .done (done_w16), .overflow (ovf_w16),
      .c_rd_addr (c_rd_addr), .c_rd_data (c_rd_data_w16)
   );

   // Reference: one C element, step by step, wrapping or clamping after every addition.
   function automatic longint elem(input int w, input bit sat, input bit sgn, input longint base,
                                   input int r, input int cc, output bit ovf);
      longint v, full, lo, hi, av, bv;
      full = longint'(1) << w;
      if (sgn) begin
         hi = (full >> 1) - 1;
         lo = -(full >> 1);
      end else begin
         hi = full - 1;
         lo = 0;
      end
      v   = base;
      ovf = 1'b0;
      for (int kk = 0; kk < N; kk++) begin
         if (sgn) begin
            av = longint'($signed(a_m[r*N+kk]));
            bv = longint'($signed(b_m[kk*N+cc]));
         end else begin
            av = longint'(a_m[r*N+kk]);
            bv = longint'(b_m[kk*N+cc]);
         end
         v = v + av * bv;
         if (v > hi || v < lo) begin
            ovf = 1'b1;
            if (sat) begin
               v = (v > hi) ? hi : lo;
            end else begin
               v = v & (full - 1);
               if (sgn && v > hi) v = v - full;
            end
         end
      end
      return v & (full - 1);
   endfunction

   function automatic longint to_val(input logic [19:0] x, input bit sgn);
      if (sgn && x[19]) return longint'(x) - (longint'(1) << 20);
      return longint'(x);
   endfunction

   task automatic model_job(input bit acc, input bit sgn);
      bit     o;
      longint base;
      sb_t    e;
      exp_ovf = 1'b0;
      for (int r = 0; r < N; r++) begin
         for (int cc = 0; cc < N; cc++) begin
            base = acc ? to_val(mc[r*N+cc], sgn) : 0;
            mc[r*N+cc] = 20'(elem(20, 1'b0, sgn, base, r, cc, o));
            exp_ovf = exp_ovf | o;
            e.addr = r * N + cc;
            e.exp  = mc[r*N+cc];
            sb_q.push_back(e);
         end
      end
   endtask

   task automatic load_ab();
      for (int e = 0; e < NN; e++) begin
         @(negedge clk);
         a_wr_en = 1'b1; a_wr_addr = 4'(e); a_wr_data = a_m[e];
         b_wr_en = 1'b1; b_wr_addr = 4'(e); b_wr_data = b_m[e];
      end
      @(negedge clk);
      a_wr_en = 1'b0;
      b_wr_en = 1'b0;
   endtask

   // Cycle 1 is the first negedge after the edge that samples start.
   task automatic run_job(input logic acc, input logic sgn, input bit disturb, output int bc,
                          output int da, output logic busy_at_done, output logic done_after);
      @(negedge clk);
      accumulate = acc; signed_mode = sgn; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      bc = 0; da = -1; busy_at_done = 1'bx; done_after = 1'bx;
      for (int c = 1; c <= 200; c++) begin
         if (disturb) begin
            start     = (c == 10);
            a_wr_en   = (c >= 12 && c < 28);
            a_wr_addr = 4'(c - 12);
            a_wr_data = 8'hFF;
         end
         if (busy === 1'b1) bc++;
         if (done === 1'b1) begin
            da = c;
            busy_at_done = busy;
            break;
         end
         @(negedge clk);
      end
      start   = 1'b0;
      a_wr_en = 1'b0;
      if (da < 0) begin
         checks++; errors++;
         $display("FAIL job_timeout: done not seen in 200 cycles, required done=1");
      end else begin
         @(negedge clk);
         done_after = done;
      end
   endtask

   task automatic drain();
      sb_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         @(negedge clk);
         c_rd_addr = 4'(e.addr);
         @(negedge clk);
         checks++;
         if (c_rd_data !== e.exp) begin
            errors++;
            $display("FAIL c_read[%0d]: got 0x%05h, required 0x%05h", e.addr, c_rd_data, e.exp);
         end
      end
   endtask

   task automatic check_ovf(input string name);
      checks++;
      if (overflow !== exp_ovf) begin
         errors++;
         $display("FAIL %s_overflow: got %b, required %b", name, overflow, exp_ovf);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks += 4;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL reset_overflow: got %b, required 0", overflow);
      end
      if (c_rd_data !== 20'd0) begin
         errors++; $display("FAIL reset_c_rd_data: got %0d, required 0", c_rd_data);
      end
      rst = 1'b0;
   endtask

   task automatic test_identity();
      int bc, da;
      logic bad, dn;
      for (int e = 0; e < NN; e++) begin
         a_m[e] = (e / N == e % N) ? 8'd1 : 8'd0;
         b_m[e] = 8'(e);
      end
      load_ab();
      model_job(1'b0, 1'b0);
      run_job(1'b0, 1'b0, 1'b0, bc, da, bad, dn);
      checks += 4;
      if (bc != 64) begin errors++; $display("FAIL ident_busy_cycles: got %0d, required 64", bc); end
      if (da != 65) begin errors++; $display("FAIL ident_done_cycle: got %0d, required 65", da); end
      if (bad !== 1'b0) begin errors++; $display("FAIL ident_busy_at_done: got %b, required 0", bad); end
      if (dn !== 1'b0) begin errors++; $display("FAIL ident_done_width: got %b, required 0", dn); end
      check_ovf("ident");
      drain();
   endtask

   task automatic test_unsigned_max();
      int bc, da;
      logic bad, dn;
      for (int e = 0; e < NN; e++) begin
         a_m[e] = 8'd255;
         b_m[e] = 8'd255;
      end
      load_ab();
      model_job(1'b0, 1'b0);
      run_job(1'b0, 1'b0, 1'b0, bc, da, bad, dn);
      check_ovf("umax");
      checks += 2;
      if (ovf_s16 !== 1'b1) begin errors++; $display("FAIL sat16_overflow: got %b, required 1", ovf_s16); end
      if (ovf_w16 !== 1'b1) begin errors++; $display("FAIL wrap16_overflow: got %b, required 1", ovf_w16); end
      for (int e = 0; e < NN; e++) begin
         @(negedge clk);
         c_rd_addr = 4'(e);
         @(negedge clk);
         checks += 2;
         if (c_rd_data_s16 !== 16'd65535) begin
            errors++; $display("FAIL sat16_c[%0d]: got %0d, required 65535", e, c_rd_data_s16);
         end
         if (c_rd_data_w16 !== 16'd63492) begin
            errors++; $display("FAIL wrap16_c[%0d]: got %0d, required 63492", e, c_rd_data_w16);
         end
      end
      drain();
   endtask

   task automatic test_signed();
      int bc, da;
      logic bad, dn;
      for (int e = 0; e < NN; e++) begin
         a_m[e] = 8'h80;
         b_m[e] = 8'h7F;
      end
      load_ab();
      model_job(1'b0, 1'b1);
      run_job(1'b0, 1'b1, 1'b0, bc, da, bad, dn);
      check_ovf("signed");
      drain();
   endtask

   task automatic test_accumulate();
      int bc, da;
      logic bad, dn;
      for (int e = 0; e < NN; e++) begin
         a_m[e] = (e / N == e % N) ? 8'd1 : 8'd0;
         b_m[e] = 8'(3 * e + 1);
      end
      load_ab();
      model_job(1'b0, 1'b0);
      run_job(1'b0, 1'b0, 1'b0, bc, da, bad, dn);
      drain();
      model_job(1'b1, 1'b0);
      run_job(1'b1, 1'b0, 1'b0, bc, da, bad, dn);
      check_ovf("accum");
      drain();
   endtask

   task automatic test_reset_mid();
      bit saw_done = 1'b0;
      @(negedge clk);
      accumulate = 1'b0; signed_mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b, required 1", busy); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after: got %b, required 0", busy); end
      for (int c = 0; c < 80; c++) begin
         if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (saw_done) begin errors++; $display("FAIL rstmid_no_done: got activity=1, required 0"); end
   endtask

   task automatic test_busy_ignore();
      int bc, da;
      logic bad, dn;
      for (int e = 0; e < NN; e++) begin
         a_m[e] = (e / N == e % N) ? 8'd1 : 8'd0;
         b_m[e] = 8'(2 * e + 1);
      end
      load_ab();
      model_job(1'b0, 1'b0);
      run_job(1'b0, 1'b0, 1'b1, bc, da, bad, dn);
      checks += 2;
      if (bc != 64) begin errors++; $display("FAIL busyign_busy_cycles: got %0d, required 64", bc); end
      if (da != 65) begin errors++; $display("FAIL busyign_done_cycle: got %0d, required 65", da); end
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL busyign_restart: got busy=%b, required 0", busy); end
      drain();
   endtask

   initial begin
      test_reset();
      test_identity();
      test_unsigned_max();
      test_signed();
      test_accumulate();
      test_reset_mid();
      test_busy_ignore();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/matmul_engine.md
# matmul_engine

Parametrised N×N matrix-multiply accelerator, successor to the fixed 4×4 multiplier, computing C = A·B or C = C + A·B. Operands are loaded into internal buffers through write ports, computed with one MAC per cycle, and read back through a registered read port. Signed or unsigned operands, optional saturation and a sticky overflow flag are supported. The block sits beside the core as a memory-mapped coprocessor.

## Interface
- N, 4: matrix dimension (2..16); element index = row*N + col
- DATA_W, 8: operand width
- ACC_W, 20: accumulator/result width (≥ 2*DATA_W)
- SATURATE, 0: 0 = wrap modulo 2^ACC_W, 1 = clamp to representable range
- AW: localparam, $clog2(N*N)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- a_wr_en / a_wr_addr / a_wr_data  in  1/AW/DATA_W  A buffer write
- b_wr_en / b_wr_addr / b_wr_data  in  1/AW/DATA_W  B buffer write
- start  in  1  job request, level-sampled in IDLE
- accumulate  in  1  sampled with start: 1 = C += A·B
- signed_mode  in  1  sampled with start: operands and C are two's complement
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- overflow  out  1  sticky; set if any result wrapped or clamped during the last job
- c_rd_addr  in  AW  C read address
- c_rd_data  out  ACC_W  C[c_rd_addr], registered, 1-cycle latency

## Operation
- States: IDLE, COMPUTE, DONE.
- IDLE: when start=1, latch accumulate and signed_mode, clear overflow, set i=j=k=0, and go to COMPUTE.
- COMPUTE: each cycle, acc_next = (k==0 ? base : acc) + A[i*N+k]*B[k*N+j].
  - base = 0, or C[i*N+j] when accumulate=1.
  - At k==N-1, write acc_next (wrapped or saturated) to C[i*N+j], then clear k and advance j, then i.
  - After i=j=k=N-1, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally. start need not drop.
- Arithmetic:
  - Product is 2*DATA_W bits, sign- or zero-extended to ACC_W+1.
  - Overflow is detected on each addition into ACC_W bits.
  - Overflow sets the sticky flag, and clamps when SATURATE=1.
  - Unsigned clamp is 2^ACC_W-1. Signed clamps are max/min of ACC_W.
- A/B writes are accepted in IDLE and DONE and ignored in COMPUTE.
- start is ignored while busy.
- C reads are allowed at any time. During COMPUTE they return current buffer contents, which may be partially updated.
- A/B/C buffers are not cleared by reset. Contents are undefined until written.

## Timing
- Reset values: busy=0, done=0, overflow=0, c_rd_data=0, state=IDLE, i=j=k=0.
- Start sampled high at edge t → busy=1 from t+1 through t+N³.
- At t+N³+1: done=1, busy=0. The next start can be accepted at the edge after done.
- Total latency is N³+1 cycles from the start edge to the done pulse (65 for N=4).
- A buffer write at edge t is visible to a job started at edge t+1.
- c_rd_data updates one edge after c_rd_addr is presented.
- Reset asserted in any state returns the block to IDLE at the next edge and aborts the job. C may be partially written, and no done pulse is generated.
- Simultaneous start and rst: rst wins.

## Structure
- Package matmul_pkg holds:
  - state enum (IDLE/COMPUTE/DONE)
  - default-parameter constants
  - a function returning saturation bounds for a given ACC_W and sign mode
- Sub-module mac_unit is combinational: sign/zero extension, multiply, add, overflow detect, wrap/clamp.
- Top-level holds the FSM, index counters, the three buffers and the read register.

## Test plan
- N=4: A = identity, B[e]=e → C[e]=e; done at cycle 65 after start, busy high exactly 64 cycles.
- Unsigned, all A/B = 255, ACC_W=20 → every C = 260100, overflow=0.
- ACC_W=16: with SATURATE=1 → C=65535, overflow=1; with SATURATE=0 → C = 260100 mod 65536 = 63492, overflow=1.
- Signed, A all = -128, B all = 127, N=4 → C = -65024.
- Accumulate=1 run twice on identity×B → C=2·B.
- Reset mid-op: rst at cycle 20 of COMPUTE → busy=0 next cycle, no done pulse.
- Start while busy is ignored.
- A writes during COMPUTE do not alter the result.
